// File: rtl/seven_segment_pkg.sv
// Shared constants and helpers for the seven-segment scan decoder.
// Holds the legal digit patterns (active-high, bit0=a .. bit6=g), the blank
// pattern, the error codes and the tracker FSM state type.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_ILLEGAL = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  typedef enum logic {
    TRACK = 1'b0,
    HOLD  = 1'b1
  } track_state_t;

  // True when exactly one bit of the digit select is set.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational segment-pattern decoder.
// Ports:
//   seg   - 7-bit segment pattern, bit0=a .. bit6=g
//   value - decoded nibble: 0..9, 4'hF for blank, 4'hE for any other pattern
//   err   - set when the pattern is not one of the ten legal digits
module seven_segment_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       err
);

  // Pattern lookup; everything outside the ten digits is flagged.
  always_comb begin
    value = CODE_ILLEGAL;
    err   = 1'b1;
    case (seg)
      SEG_0:     begin value = 4'd0; err = 1'b0; end
      SEG_1:     begin value = 4'd1; err = 1'b0; end
      SEG_2:     begin value = 4'd2; err = 1'b0; end
      SEG_3:     begin value = 4'd3; err = 1'b0; end
      SEG_4:     begin value = 4'd4; err = 1'b0; end
      SEG_5:     begin value = 4'd5; err = 1'b0; end
      SEG_6:     begin value = 4'd6; err = 1'b0; end
      SEG_7:     begin value = 4'd7; err = 1'b0; end
      SEG_8:     begin value = 4'd8; err = 1'b0; end
      SEG_9:     begin value = 4'd9; err = 1'b0; end
      SEG_BLANK: begin value = CODE_BLANK; err = 1'b1; end
      default:   begin value = CODE_ILLEGAL; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Seven-segment scan decoder: snoops a multiplexed 4-digit display drive
// (segment pattern + one-hot digit select), accepts a digit once its
// pattern/select pair has been stable for STABLE_CYCLES samples, and emits a
// decoded 4-digit frame once every digit position has been seen.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   seg         - segment pattern (bit0=a .. bit6=g)
//   an          - one-hot digit select, an[i] selects digit i
//   digits      - decoded frame, digit i in bits [4i+3:4i]
//   frame_valid - one-cycle pulse when digits/digit_err/frame_err update
//   digit_err   - per-digit illegal-pattern flags
//   frame_err   - OR of digit_err
module seven_segment_scan_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic        frame_valid,
  output logic [3:0]  digit_err,
  output logic        frame_err
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]       seg_r;
  logic [3:0]       an_r;
  logic [10:0]      prev_r;      // {seg_r, an_r} as seen on the previous edge
  logic [CNT_W-1:0] cnt_r;
  track_state_t     state_r;
  track_state_t     state_next_s;
  logic [3:0]       seen_r;
  logic [15:0]      buf_val_r;
  logic [3:0]       buf_err_r;

  logic             changed_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             capture_s;
  logic             frame_done_s;
  logic [3:0]       dec_value_s;
  logic             dec_err_s;

  seven_segment_pattern_decode u_decode (
    .seg   (seg_r),
    .value (dec_value_s),
    .err   (dec_err_s)
  );

  // Input registers and previous-sample copy for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r  <= 7'd0;
      an_r   <= 4'd0;
      prev_r <= 11'd0;
    end else begin
      seg_r  <= seg;
      an_r   <= an;
      prev_r <= {seg_r, an_r};
    end
  end

  // Stability counter next value and capture qualification.
  always_comb begin
    changed_s  = ({seg_r, an_r} != prev_r);
    cnt_next_s = cnt_r;
    if (changed_s) begin
      cnt_next_s = CNT_ONE;
    end else if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
    // Capture on the edge where the count of identical samples hits the target.
    capture_s    = (state_r == TRACK) && is_one_hot(an_r) && (cnt_next_s == CNT_MAX);
    frame_done_s = (seen_r == 4'b1111);
  end

  // Tracker FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      TRACK: begin
        if (capture_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = TRACK;
        end
      end
      HOLD: begin
        if (changed_s) begin
          state_next_s = TRACK;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = TRACK;
    endcase
  end

  // Counter and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      state_r <= TRACK;
    end else begin
      cnt_r   <= cnt_next_s;
      state_r <= state_next_s;
    end
  end

  // Frame buffer and seen-mask; a capture on the completion edge starts the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_r    <= 4'b0000;
      buf_val_r <= 16'h0000;
      buf_err_r <= 4'b0000;
    end else begin
      if (frame_done_s) begin
        seen_r <= capture_s ? an_r : 4'b0000;
      end else if (capture_s) begin
        seen_r <= seen_r | an_r;
      end
      for (int i = 0; i < 4; i++) begin
        if (capture_s && an_r[i]) begin
          buf_val_r[4*i +: 4] <= dec_value_s;
          buf_err_r[i]        <= dec_err_s;
        end
      end
    end
  end

  // Output frame registers; load the buffer as it stood before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 16'h0000;
      digit_err   <= 4'b0000;
      frame_err   <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done_s;
      if (frame_done_s) begin
        digits    <= buf_val_r;
        digit_err <= buf_err_r;
        frame_err <= |buf_err_r;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Self-checking bench for seven_segment_scan_decoder (STABLE_CYCLES = 4).
// Expected frames are queued when the completing digit is driven and are
// popped and compared whenever the DUT pulses frame_valid.
module tb_seven_segment_scan_decoder;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  e;
    logic        f;
  } frame_t;

  localparam logic [6:0] PAT [0:9] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

  logic        clk;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic        frame_valid;
  logic [3:0]  digit_err;
  logic        frame_err;

  int tests_run    = 0;
  int tests_failed = 0;
  frame_t exp_q[$];
  frame_t exp_cur;

  seven_segment_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .frame_valid (frame_valid),
    .digit_err   (digit_err),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a pattern/select pair so it is stable across exactly n rising edges.
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] e);
    frame_t fr;
    fr.d = d;
    fr.e = e;
    fr.f = |e;
    exp_q.push_back(fr);
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest queued frame.
  always @(posedge clk) begin
    #1;
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 32'd1, 32'd0);
      end else begin
        exp_cur = exp_q.pop_front();
        check("digits", {16'd0, digits}, {16'd0, exp_cur.d});
        check("digit_err", {28'd0, digit_err}, {28'd0, exp_cur.e});
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_cur.f});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    seg = 7'd0;
    an  = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", {16'd0, digits}, 32'd0);
    check("rst_digit_err", {28'd0, digit_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic scan 0,1,2,3 with exact frame latency and pulse width.
    dwell(4'b0001, PAT[0], 6);
    dwell(4'b0010, PAT[1], 6);
    dwell(4'b0100, PAT[2], 6);
    push(16'h3210, 4'b0000);
    dwell(4'b1000, PAT[3], 5);
    #1;
    check("lat_early", {31'd0, frame_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_pulse", {31'd0, frame_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("pulse_width", {31'd0, frame_valid}, 32'd0);
    check("digits_hold", {16'd0, digits}, 32'h0000_3210);

    // Remaining legal digits.
    dwell(4'b0001, PAT[4], 6);
    dwell(4'b0010, PAT[5], 6);
    dwell(4'b0100, PAT[6], 6);
    push(16'h7654, 4'b0000);
    dwell(4'b1000, PAT[7], 6);
    dwell(4'b0001, PAT[8], 6);
    dwell(4'b0010, PAT[9], 6);
    dwell(4'b0100, PAT[0], 6);
    push(16'h1098, 4'b0000);
    dwell(4'b1000, PAT[1], 6);

    // Digit 2 too short (3 samples) is not captured; a later 4-sample dwell is.
    dwell(4'b0001, PAT[0], 6);
    dwell(4'b0010, PAT[1], 6);
    dwell(4'b0100, PAT[2], 3);
    dwell(4'b1000, PAT[3], 10);
    push(16'h3510, 4'b0000);
    dwell(4'b0100, PAT[5], 4);

    // Blank and illegal patterns.
    dwell(4'b0001, PAT[0], 6);
    dwell(4'b0010, 7'b0000000, 6);
    dwell(4'b0100, PAT[2], 6);
    push(16'hE2F0, 4'b1010);
    dwell(4'b1000, 7'b1110001, 8);
    repeat (5) @(posedge clk);
    #1;
    check("err_hold", {31'd0, frame_err}, 32'd1);

    // Multi-hot and zero selects never capture; digit 0 is overwritten.
    dwell(4'b0011, PAT[8], 10);
    dwell(4'b0000, PAT[8], 10);
    dwell(4'b0100, PAT[6], 6);
    dwell(4'b1000, PAT[9], 6);
    dwell(4'b0001, PAT[7], 6);
    dwell(4'b0001, PAT[1], 6);
    push(16'h9641, 4'b0000);
    dwell(4'b0010, PAT[4], 8);

    // Long dwell, then reset mid-frame discards the partial frame.
    dwell(4'b0001, PAT[7], 40);
    dwell(4'b0010, PAT[0], 6);
    dwell(4'b0100, PAT[3], 6);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_digits", {16'd0, digits}, 32'd0);
    check("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dwell(4'b1000, PAT[5], 16);
    dwell(4'b0001, PAT[2], 6);
    dwell(4'b0010, PAT[8], 6);
    push(16'h5482, 4'b0000);
    dwell(4'b0100, PAT[4], 8);

    repeat (20) @(posedge clk);
    #1;
    check("pending_frames", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
